// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares one register-file write port among 4 requesters. In IDLE a winner is
// picked (highest index by default) and owns the port in GRANT, writing one item
// per cycle while it keeps req high, for at most MAX_HOLD writes per grant.
//
// Ports:
//   clk, reset         clock (rising edge), synchronous active-high reset
//   req[3:0]           per-requester request, held while an item is pending
//   req_addr, req_data packed per-requester write address / data slots
//   ack[3:0]           combinational one-hot: owner's item consumed at this edge
//   rf_we/addr/data    registered register-file write port
//   grant_code         registered: 0 = no owner, i+1 = requester i owns the port
//   busy               registered: 1 while in GRANT
//
// Optional build macro REGFILE_ARB_ROUND_ROBIN_EN: IDLE scans requesters starting
// just below the last owner (last_owner-1, -2, -3, last_owner) instead of using
// fixed highest-index priority.
//
// state | meaning
// IDLE  | no owner; arbitrate on any request (one bubble cycle per re-arbitration)
// GRANT | owner holds the port; one write per edge while req[owner] stays high

module regfile_write_arbiter #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            req,
    input  logic [4*ADDR_W-1:0]   req_addr,
    input  logic [4*DATA_W-1:0]   req_data,
    output logic [3:0]            ack,
    output logic                  rf_we,
    output logic [ADDR_W-1:0]     rf_addr,
    output logic [DATA_W-1:0]     rf_data,
    output logic [2:0]            grant_code,
    output logic                  busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

    state_t     state;
    logic [1:0] owner;
    logic [1:0] winner;
    logic [3:0] cnt;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    logic [1:0] last_owner;

    // Scan order last_owner-1 .. last_owner (mod 4); first requester found wins.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_owner - 2'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end
`else
    // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        winner = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (req[i]) winner = 2'(i);
        end
    end
`endif

    // Gated by reset so no item is consumed on an edge that writes nothing.
    always_comb begin
        ack = 4'b0000;
        if (state == GRANT && !reset) ack[owner] = req[owner];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 2'd0;
            cnt        <= 4'd0;
            rf_we      <= 1'b0;
            rf_addr    <= '0;
            rf_data    <= '0;
            grant_code <= 3'd0;
            busy       <= 1'b0;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
            last_owner <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    rf_we <= 1'b0;
                    if (|req) begin
                        owner      <= winner;
                        cnt        <= 4'd0;
                        state      <= GRANT;
                        grant_code <= {1'b0, winner} + 3'd1;
                        busy       <= 1'b1;
                    end else begin
                        grant_code <= 3'd0;
                        busy       <= 1'b0;
                    end
                end
                GRANT: begin
                    if (req[owner]) begin
                        rf_we   <= 1'b1;
                        rf_addr <= req_addr[owner*ADDR_W +: ADDR_W];
                        rf_data <= req_data[owner*DATA_W +: DATA_W];
                        cnt     <= cnt + 4'd1;
                    end else begin
                        rf_we <= 1'b0;
                    end
                    // Leave on a dropped request or on the burst limit.
                    if (!req[owner] || (cnt + 4'd1 == HOLD_LIM)) begin
                        state      <= IDLE;
                        grant_code <= 3'd0;
                        busy       <= 1'b0;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
                        last_owner <= owner;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
